serial_addsub: RTL and testbench

- Parametrised, multi-cycle adder/subtractor/comparator for the MIPS datapath; next generation of the combinational {carry,res} = a ± b experiments.
- Processes WIDTH-bit operands in SLICE-bit chunks, one chunk per clock, with the carry held in a register between chunks.
- Produces ADD/SUB/SLT/SLTU results plus carry, overflow and zero flags.
- Uses a valid/ready handshake on both input and output so the execute-stage controller can stall it.

---
 rtl/serial_addsub.sv | 225 ++++++++++++++++++++++
 tb/tb_serial_addsub.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//
// Multi-cycle adder / subtractor / comparator for the MIPS execute stage.
// The WIDTH-bit operands are processed SLICE bits per clock. The carry ripples
// between slices through a register, so a full operation takes
// NSLICE = WIDTH/SLICE clocks after acceptance.
//
// Operations (op):
//   2'b00 ADD  : result = a + b
//   2'b01 SUB  : result = a - b
//   2'b10 SLT  : result = (signed a < signed b), zero-extended
//   2'b11 SLTU : result = (unsigned a < unsigned b), zero-extended
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : operands and op are valid
//   in_ready   : operands are accepted this cycle (IDLE, or DONE with out_ready)
//   op         : operation select
//   a, b       : operands
//   out_valid  : result and flags are valid (held until out_ready)
//   out_ready  : consumer takes the result this cycle
//   result     : sum, difference or compare bit
//   carry      : ADD carry out; SUB/SLT/SLTU borrow (a < b unsigned)
//   overflow   : signed overflow of the underlying add or subtract
//   zero       : result == 0
//
// Optional feature, enabled by defining SERIAL_ADDSUB_STICKY_OVF_EN:
//   ovf_clr    : synchronous clear of the sticky overflow flag
//   ovf_sticky : set by any ADD/SUB that overflows, held until cleared
//                (a set on the same edge as a clear wins)
// -----------------------------------------------------------------------------
module serial_addsub #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
`ifdef SERIAL_ADDSUB_STICKY_OVF_EN
    ,
    input  logic             ovf_clr,
    output logic             ovf_sticky
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NSLICE - 1);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_SLT  = 2'b10;
    localparam logic [1:0] OP_SLTU = 2'b11;

    generate
        if ((SLICE < 1) || (WIDTH < SLICE) || ((WIDTH % SLICE) != 0)) begin : g_bad_param
            $error("serial_addsub: WIDTH must be a non-zero multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Operand capture (b already inverted for the subtract-based ops)
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;

    // Slice control and result/flag registers
    logic [KW-1:0]    k_q;
    logic             c_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             ovf_q;
    logic             zero_q;

    // One slice of the ripple adder, carry out in the top bit
    function automatic logic [SLICE:0] slice_add(input logic [SLICE-1:0] x,
                                                 input logic [SLICE-1:0] y,
                                                 input logic             cin);
        return {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, cin};
    endfunction

    logic             accept;
    logic             last;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE:0]   sum_ext;
    logic [WIDTH-1:0] full_sum;
    logic             fin_ovf;
    logic             fin_cout;
    logic             fin_carry;
    logic [WIDTH-1:0] fin_res;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign last      = (k_q == KLAST);
    assign out_valid = (state_q == DONE);

    assign result   = result_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

    // Current slice arithmetic and final-slice result/flag formation
    always_comb begin
        a_sl     = a_q[int'(k_q)*SLICE +: SLICE];
        b_sl     = b_q[int'(k_q)*SLICE +: SLICE];
        sum_ext  = slice_add(a_sl, b_sl, c_q);

        // Lower slices were written on earlier edges of this operation
        full_sum = result_q;
        full_sum[int'(k_q)*SLICE +: SLICE] = sum_ext[SLICE-1:0];

        fin_cout  = sum_ext[SLICE];
        fin_ovf   = (a_sl[SLICE-1] == b_sl[SLICE-1]) &&
                    (sum_ext[SLICE-1] != a_sl[SLICE-1]);
        // Subtraction is a + ~b + 1, so no carry out means a borrow
        fin_carry = (op_q == OP_ADD) ? fin_cout : ~fin_cout;

        fin_res = '0;
        case (op_q)
            OP_SLT:  fin_res[0] = sum_ext[SLICE-1] ^ fin_ovf;
            OP_SLTU: fin_res[0] = ~fin_cout;
            default: fin_res    = full_sum;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = RUN;
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = in_valid ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand registers only matter after acceptance, so they need no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= a;
            b_q  <= (op != OP_ADD) ? ~b : b;
            op_q <= op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q      <= '0;
            c_q      <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else if (accept) begin
            // Carry-in of 1 completes the two's complement of b
            c_q <= (op != OP_ADD);
            k_q <= '0;
        end else if (state_q == RUN) begin
            c_q <= fin_cout;
            k_q <= k_q + 1'b1;
            if (last) begin
                result_q <= fin_res;
                carry_q  <= fin_carry;
                ovf_q    <= fin_ovf;
                zero_q   <= (fin_res == '0);
            end else begin
                result_q[int'(k_q)*SLICE +: SLICE] <= sum_ext[SLICE-1:0];
            end
        end
    end

`ifdef SERIAL_ADDSUB_STICKY_OVF_EN
    logic sticky_q;
    logic sticky_set;

    assign sticky_set = (state_q == RUN) && last && fin_ovf &&
                        ((op_q == OP_ADD) || (op_q == OP_SUB));
    assign ovf_sticky = sticky_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (sticky_set) begin
            sticky_q <= 1'b1;
        end else if (ovf_clr) begin
            sticky_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

    localparam int W  = 8;
    localparam int S  = 4;
    localparam int NS = W / S;

    localparam logic [1:0] ADD  = 2'b00;
    localparam logic [1:0] SUB  = 2'b01;
    localparam logic [1:0] SLT  = 2'b10;
    localparam logic [1:0] SLTU = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;
`ifdef SERIAL_ADDSUB_STICKY_OVF_EN
    logic         ovf_clr = 1'b0;
    logic         ovf_sticky;
`endif

    serial_addsub #(.WIDTH(W), .SLICE(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero)
`ifdef SERIAL_ADDSUB_STICKY_OVF_EN
        ,
        .ovf_clr   (ovf_clr),
        .ovf_sticky(ovf_sticky)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        exp_t         e;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the unsigned / signed values
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int lim, ux, uy, sx, sy, r, sr;
        lim = 1 << W;
        ux  = int'(x);
        uy  = int'(y);
        sx  = (ux >= lim / 2) ? ux - lim : ux;
        sy  = (uy >= lim / 2) ? uy - lim : uy;
        if (o == ADD) begin
            r   = ux + uy;
            sr  = sx + sy;
            e.c = (r >= lim);
        end else begin
            r   = ux - uy;
            sr  = sx - sy;
            e.c = (ux < uy);
        end
        e.v = (sr > lim / 2 - 1) || (sr < -(lim / 2));
        case (o)
            SLT:     e.res = (sx < sy) ? W'(1) : W'(0);
            SLTU:    e.res = (ux < uy) ? W'(1) : W'(0);
            default: e.res = W'(r & (lim - 1));
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    function automatic vec_t mk(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [W-1:0] r, input logic c, input logic v, input logic z);
        vec_t t;
        t.op = o; t.a = x; t.b = y;
        t.e.res = r; t.e.c = c; t.e.v = v; t.e.z = z;
        return t;
    endfunction

    // Wait (bounded) for out_valid, starting #1 after an acceptance edge
    task automatic wait_result(input string tag, output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("%s latency", tag), lat, NS);
    endtask

    task automatic compare_out(input string tag, input exp_t e);
        check($sformatf("%s out_valid", tag), out_valid, 1);
        check($sformatf("%s result", tag), result, e.res);
        check($sformatf("%s carry", tag), carry, e.c);
        check($sformatf("%s overflow", tag), overflow, e.v);
        check($sformatf("%s zero", tag), zero, e.z);
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check($sformatf("%s out_valid drop", tag), out_valid, 0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input exp_t e, input string tag);
        int lat;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
        check($sformatf("%s in_ready", tag), in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Operand changes during RUN must not matter
        op = 2'($urandom); a = W'($urandom); b = W'($urandom);
        wait_result(tag, lat);
        compare_out(tag, e);
        consume(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int   lat;
        logic [1:0]   ro;
        logic [W-1:0] rx, ry;

        vecs.push_back(mk(ADD,  8'd255, 8'd1,   8'd0,   1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(ADD,  8'd100, 8'd100, 8'd200, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(SUB,  8'd8,   8'd8,   8'd0,   1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(SUB,  8'd1,   8'd255, 8'd2,   1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(SLT,  8'hF6,  8'd1,   8'd1,   1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(SLTU, 8'hF6,  8'd1,   8'd0,   1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(SUB,  8'h80,  8'd1,   8'h7F,  1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(SLT,  8'h80,  8'h7F,  8'd1,   1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(SLTU, 8'd1,   8'd2,   8'd1,   1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(ADD,  8'h7F,  8'd1,   8'h80,  1'b0, 1'b1, 1'b0));

        // Reset state
        #2;
        check("reset out_valid", out_valid, 0);
        check("reset result", result, 0);
        check("reset flags", {carry, overflow, zero}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset in_ready", in_ready, 1);

        // Directed table
        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, $sformatf("vec%0d", i));

`ifdef SERIAL_ADDSUB_STICKY_OVF_EN
        @(negedge clk); ovf_clr = 1'b1;
        @(posedge clk); #1; ovf_clr = 1'b0;
        check("sticky cleared", ovf_sticky, 0);
        run_op(ADD, 8'd100, 8'd100, model(ADD, 8'd100, 8'd100), "sticky add");
        check("sticky set", ovf_sticky, 1);
        run_op(ADD, 8'd1, 8'd2, model(ADD, 8'd1, 8'd2), "sticky hold");
        check("sticky held", ovf_sticky, 1);
        @(negedge clk); ovf_clr = 1'b1;
        @(posedge clk); #1; ovf_clr = 1'b0;
        check("sticky clr", ovf_sticky, 0);
        run_op(SLT, 8'h80, 8'h7F, model(SLT, 8'h80, 8'h7F), "sticky slt");
        check("sticky slt no set", ovf_sticky, 0);
`endif

        // Back-pressure: result held while out_ready is low
        @(negedge clk);
        op = ADD; a = 8'd100; b = 8'd100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result("bp first", lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp hold%0d", i),
                  {out_valid, in_ready, result, carry, overflow, zero},
                  {1'b1, 1'b0, 8'd200, 1'b0, 1'b1, 1'b0});
        end
        // Consume and accept on the same edge
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; op = SUB; a = 8'd8; b = 8'd8;
        #1;
        check("bp in_ready comb", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("bp b2b out_valid low", out_valid, 0);
        wait_result("bp second", lat);
        compare_out("bp second", model(SUB, 8'd8, 8'd8));
        consume("bp second");

        // Reset in the middle of RUN
        @(negedge clk);
        op = ADD; a = 8'd200; b = 8'd100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", out_valid, 0);
        check("midrst result", result, 0);
        check("midrst flags", {carry, overflow, zero}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst in_ready", in_ready, 1);
        run_op(ADD, 8'd3, 8'd4, model(ADD, 8'd3, 8'd4), "post reset");
        check("post reset 3+4", model(ADD, 8'd3, 8'd4).res, 8'd7);

        // Randomized against the reference model
        for (int i = 0; i < 150; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = W'($urandom);
            ry = W'($urandom);
            run_op(ro, rx, ry, model(ro, rx, ry), $sformatf("rand%0d op%0d %0h,%0h", i, ro, rx, ry));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
